// File: rtl/amplitude_smoother.sv
// Gain-smoothing sample scaler: out = (signed sample * unsigned gain) >> 16, gain slewing toward target_amp.
// Latency: 2 cycles from input acceptance to sample_out_valid (S1 operand register, S2 product register).
// Backpressure: pipeline advances only when the output is empty or taken; sample_in_ready mirrors that.
// Build option: define AMP_SMOOTHER_RAMP_EN to slew the gain by STEP per accepted sample;
// otherwise the gain jumps straight to target_amp on each accepted sample.
module amplitude_smoother #(
    parameter logic [15:0] STEP = 16'h0100
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic [15:0] target_amp,
    input  logic [15:0] sample_in,
    input  logic        sample_in_valid,
    output logic        sample_in_ready,
    output logic [15:0] sample_out,
    output logic        sample_out_valid,
    input  logic        sample_out_ready,
    output logic [15:0] cur_amp,
    output logic        ramping
);

`ifdef AMP_SMOOTHER_RAMP_EN
    localparam bit RAMP_EN = 1'b1;
`else
    localparam bit RAMP_EN = 1'b0;
`endif

    typedef enum logic [1:0] {
        SETTLED   = 2'd0,
        RAMP_UP   = 2'd1,
        RAMP_DOWN = 2'd2
    } state_t;

    // Gain FSM state
    state_t      r_state;
    logic [15:0] r_cur_amp;
    logic        r_ramping;

    // S1: captured sample and the gain in force when it was accepted
    logic        r_s1_vld;
    logic [15:0] r_s1_smp;
    logic [15:0] r_s1_amp;

    // S2: scaled output
    logic        r_out_vld;
    logic [15:0] r_out_dat;

    // Handshake and datapath wires
    logic               w_advance;
    logic               w_accept;
    logic signed [32:0] w_prod;
    logic               w_unused_prod;

    // Next-gain decision wires
    logic [15:0] w_up_diff;
    logic [15:0] w_dn_diff;
    logic        w_up_far;
    logic        w_dn_far;
    logic [15:0] w_nxt_amp;
    state_t      w_nxt_state;

    // Whole pipeline moves in lockstep: it may advance whenever the output
    // register is empty or is being consumed this cycle.
    assign w_advance = !r_out_vld || sample_out_ready;

    // While in reset the block advertises ready so upstream never stalls on
    // it, but nothing is actually taken in.
    assign sample_in_ready = !Reset || w_advance;
    assign w_accept        = Reset && sample_in_valid && w_advance;

    // Distances to the target; each is only meaningful on its own side, so
    // the magnitude compare guards against the wrapped value.
    assign w_up_diff = target_amp - r_cur_amp;
    assign w_dn_diff = r_cur_amp - target_amp;
    assign w_up_far  = (r_cur_amp < target_amp) && (w_up_diff > STEP);
    assign w_dn_far  = (r_cur_amp > target_amp) && (w_dn_diff > STEP);

    // Next gain: step toward the target while more than one STEP away,
    // otherwise land exactly on it (this is what prevents overshoot/wrap,
    // since a step is only taken when it stays strictly short of the target).
    always_comb begin
        w_nxt_amp   = target_amp;
        w_nxt_state = SETTLED;
        if (RAMP_EN && w_up_far) begin
            w_nxt_amp   = r_cur_amp + STEP;
            w_nxt_state = RAMP_UP;
        end else if (RAMP_EN && w_dn_far) begin
            w_nxt_amp   = r_cur_amp - STEP;
            w_nxt_state = RAMP_DOWN;
        end
    end

    // Gain FSM: re-evaluated only when a sample is accepted, so the gain is
    // frozen during stalls and idle periods.
    always_ff @(posedge Clk) begin
        if (!Reset) begin
            r_state   <= SETTLED;
            r_cur_amp <= 16'h0000;
            r_ramping <= 1'b0;
        end else if (w_accept) begin
            r_state   <= w_nxt_state;
            r_cur_amp <= w_nxt_amp;
            r_ramping <= (w_nxt_state != SETTLED);
        end
    end

    // S1: capture the sample together with the pre-update gain.
    always_ff @(posedge Clk) begin
        if (!Reset) begin
            r_s1_vld <= 1'b0;
            r_s1_smp <= 16'h0000;
            r_s1_amp <= 16'h0000;
        end else if (w_advance) begin
            r_s1_vld <= sample_in_valid;
            if (sample_in_valid) begin
                r_s1_smp <= sample_in;
                r_s1_amp <= r_cur_amp;
            end
        end
    end

    // Signed sample times zero-extended gain; the magnitude never exceeds
    // 2^31, so bits [31:16] are the exact Q16 scaled result.
    assign w_prod        = $signed(r_s1_smp) * $signed({1'b0, r_s1_amp});
    assign w_unused_prod = ^{w_prod[32], w_prod[15:0]};

    // S2: register the scaled sample; data only changes when a valid
    // sample moves in, so a bubble leaves the last value on the bus.
    always_ff @(posedge Clk) begin
        if (!Reset) begin
            r_out_vld <= 1'b0;
            r_out_dat <= 16'h0000;
        end else if (w_advance) begin
            r_out_vld <= r_s1_vld;
            if (r_s1_vld) begin
                r_out_dat <= w_prod[31:16];
            end
        end
    end

    assign sample_out       = r_out_dat;
    assign sample_out_valid = r_out_vld;
    assign cur_amp          = r_cur_amp;
    assign ramping          = r_ramping;

endmodule

// File: tb/tb_amplitude_smoother.sv
module tb_amplitude_smoother;

    localparam logic [15:0] STEP = 16'h0100;

    logic        Clk;
    logic        Reset;
    logic [15:0] target_amp;
    logic [15:0] sample_in;
    logic        sample_in_valid;
    logic        sample_in_ready;
    logic [15:0] sample_out;
    logic        sample_out_valid;
    logic        sample_out_ready;
    logic [15:0] cur_amp;
    logic        ramping;

    amplitude_smoother #(.STEP(STEP)) dut (
        .Clk              (Clk),
        .Reset            (Reset),
        .target_amp       (target_amp),
        .sample_in        (sample_in),
        .sample_in_valid  (sample_in_valid),
        .sample_in_ready  (sample_in_ready),
        .sample_out       (sample_out),
        .sample_out_valid (sample_out_valid),
        .sample_out_ready (sample_out_ready),
        .cur_amp          (cur_amp),
        .ramping          (ramping)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    int unsigned n_checks = 0;
    int unsigned n_pass   = 0;

    logic [15:0] q[$];
    logic        tbl_mode = 1'b0;
    logic [15:0] m_amp    = 16'h0000;
    logic        m_ramp   = 1'b0;

    typedef struct {
        logic [15:0] tgt;
        logic [15:0] smp;
        logic [15:0] out;
        logic [15:0] amp;
        logic        rmp;
    } vec_t;

    vec_t tbl[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    endtask

    function automatic vec_t mk(input logic [15:0] tgt, input logic [15:0] smp,
                                input logic [15:0] out, input logic [15:0] amp, input logic rmp);
        vec_t v;
        v.tgt = tgt; v.smp = smp; v.out = out; v.amp = amp; v.rmp = rmp;
        return v;
    endfunction

    // Reference scaling using wide integer arithmetic.
    function automatic logic [15:0] f_scale(input logic [15:0] s, input logic [15:0] a);
        longint      sv;
        longint      av;
        longint      pp;
        logic [63:0] u;
        sv = longint'($signed(s));
        av = longint'({48'h0, a});
        pp = sv * av;
        u  = pp;
        return u[31:16];
    endfunction

    // Reference gain update; sets ramp flag as a side output.
    task automatic model_update(input logic [15:0] tgt);
`ifdef AMP_SMOOTHER_RAMP_EN
        if (m_amp < tgt && (tgt - m_amp) > STEP) begin
            m_amp = m_amp + STEP; m_ramp = 1'b1;
        end else if (m_amp > tgt && (m_amp - tgt) > STEP) begin
            m_amp = m_amp - STEP; m_ramp = 1'b1;
        end else begin
            m_amp = tgt; m_ramp = 1'b0;
        end
`else
        m_amp  = tgt;
        m_ramp = 1'b0;
`endif
    endtask

    // Monitor / scoreboard, sampled on the falling edge.
    always @(negedge Clk) begin
        if (!Reset) begin
            q.delete();
            m_amp  = 16'h0000;
            m_ramp = 1'b0;
        end else begin
            check("cur_amp", cur_amp, m_amp);
            check("ramping", ramping, m_ramp);
            if (sample_out_valid && sample_out_ready) begin
                if (q.size() == 0) begin
                    n_checks++;
                    $display("FAIL unexpected_out: got %h, expected no output (t=%0t)", sample_out, $time);
                end else begin
                    check("sample_out", sample_out, q.pop_front());
                end
            end
            if (sample_in_valid && sample_in_ready) begin
                if (!tbl_mode) q.push_back(f_scale(sample_in, m_amp));
                model_update(target_amp);
            end
        end
    end

    task automatic do_reset();
        Reset = 1'b0;
        sample_in_valid = 1'b0;
        sample_out_ready = 1'b1;
        repeat (2) @(posedge Clk);
        #1;
        Reset = 1'b1;
    endtask

    task automatic drain();
        int k = 0;
        while (q.size() != 0 && k < 20) begin
            @(posedge Clk);
            k++;
        end
        #1;
        check("drain_queue_empty", q.size(), 0);
    endtask

    // One accepted sample with explicit expectations.
    task automatic send_one(input string name, input logic [15:0] tgt, input logic [15:0] smp,
                            input logic [15:0] exp_out, input logic [15:0] exp_amp, input logic exp_rmp);
        target_amp       = tgt;
        sample_in        = smp;
        sample_in_valid  = 1'b1;
        sample_out_ready = 1'b1;
        q.push_back(exp_out);
        #1;
        check({name, "_ready"}, sample_in_ready, 1'b1);
        @(posedge Clk);
        #1;
        sample_in_valid = 1'b0;
        check({name, "_amp"}, cur_amp, exp_amp);
        check({name, "_ramping"}, ramping, exp_rmp);
    endtask

    // Stream n samples (optionally incrementing), with an optional output stall.
    task automatic run_stream(input int n, input logic [15:0] s0, input bit inc,
                              input int stall_at, input int stall_len);
        int acc = 0;
        int cyc = 0;
        bit took;
        sample_in       = s0;
        sample_in_valid = 1'b1;
        while (acc < n && cyc < 2000) begin
            sample_out_ready = !(cyc >= stall_at && cyc < stall_at + stall_len);
            @(negedge Clk);
            took = sample_in_ready;
            if (!sample_out_ready) begin
                check("stall_in_ready", sample_in_ready, 1'b0);
                check("stall_out_vld", sample_out_valid, 1'b1);
                if (q.size() != 0) check("stall_out_hold", sample_out, q[0]);
            end
            @(posedge Clk);
            #1;
            if (took) begin
                acc++;
                if (inc) sample_in = sample_in + 16'h0001;
            end
            cyc++;
        end
        sample_in_valid  = 1'b0;
        sample_out_ready = 1'b1;
        check("stream_accept_count", acc, n);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        Reset            = 1'b0;
        target_amp       = 16'h0000;
        sample_in        = 16'h0000;
        sample_in_valid  = 1'b0;
        sample_out_ready = 1'b1;

`ifdef AMP_SMOOTHER_RAMP_EN
        tbl.push_back(mk(16'h0300, 16'h4000, 16'h0000, 16'h0100, 1'b1));
        tbl.push_back(mk(16'h0300, 16'h4000, 16'h0040, 16'h0200, 1'b1));
        tbl.push_back(mk(16'h0300, 16'h4000, 16'h0080, 16'h0300, 1'b0));
        tbl.push_back(mk(16'h0300, 16'h7FFF, 16'h017F, 16'h0300, 1'b0));
        tbl.push_back(mk(16'h0000, 16'h4000, 16'h00C0, 16'h0200, 1'b1));
        tbl.push_back(mk(16'h0250, 16'h8000, 16'hFF00, 16'h0250, 1'b0));
        tbl.push_back(mk(16'h0250, 16'h0001, 16'h0000, 16'h0250, 1'b0));
`else
        tbl.push_back(mk(16'hA000, 16'h4000, 16'h0000, 16'hA000, 1'b0));
        tbl.push_back(mk(16'hA000, 16'h4000, 16'h2800, 16'hA000, 1'b0));
        tbl.push_back(mk(16'hFFFF, 16'h8000, 16'hB000, 16'hFFFF, 1'b0));
        tbl.push_back(mk(16'hFFFF, 16'h8000, 16'h8000, 16'hFFFF, 1'b0));
        tbl.push_back(mk(16'hFFFF, 16'h7FFF, 16'h7FFE, 16'hFFFF, 1'b0));
        tbl.push_back(mk(16'h0000, 16'h0001, 16'h0000, 16'h0000, 1'b0));
        tbl.push_back(mk(16'h1234, 16'h7FFF, 16'h0000, 16'h1234, 1'b0));
        tbl.push_back(mk(16'h1234, 16'hFFFF, 16'hFFFF, 16'h1234, 1'b0));
        tbl.push_back(mk(16'h8000, 16'hC000, 16'hFB73, 16'h8000, 1'b0));
        tbl.push_back(mk(16'h8000, 16'h0002, 16'h0001, 16'h8000, 1'b0));
`endif

        // Reset state, observed while reset is still asserted.
        repeat (2) @(posedge Clk);
        #1;
        check("rst_out_vld", sample_out_valid, 1'b0);
        check("rst_out", sample_out, 16'h0000);
        check("rst_amp", cur_amp, 16'h0000);
        check("rst_ramping", ramping, 1'b0);
        check("rst_in_ready", sample_in_ready, 1'b1);
        Reset = 1'b1;

        // Table-driven vectors.
        tbl_mode = 1'b1;
        for (int i = 0; i < tbl.size(); i++) begin
            send_one($sformatf("vec%0d", i), tbl[i].tgt, tbl[i].smp, tbl[i].out, tbl[i].amp, tbl[i].rmp);
        end
        drain();
        tbl_mode = 1'b0;

        // Backpressure: incrementing stream with a 5-cycle output stall.
        run_stream(12, 16'h0100, 1'b1, 4, 5);
        drain();

`ifdef AMP_SMOOTHER_RAMP_EN
        // Full ramp from 0 to FFFF.
        do_reset();
        target_amp = 16'hFFFF;
        run_stream(255, 16'h4000, 1'b0, 0, 0);
        check("ramp255_amp", cur_amp, 16'hFF00);
        check("ramp255_ramping", ramping, 1'b1);
        run_stream(1, 16'h4000, 1'b0, 0, 0);
        check("ramp256_amp", cur_amp, 16'hFFFF);
        check("ramp256_ramping", ramping, 1'b0);
        drain();

        // Full-scale products at gain FFFF.
        tbl_mode = 1'b1;
        send_one("fs_neg", 16'hFFFF, 16'h8000, 16'h8000, 16'hFFFF, 1'b0);
        send_one("fs_pos", 16'hFFFF, 16'h7FFF, 16'h7FFE, 16'hFFFF, 1'b0);
        send_one("fs_one", 16'hFFFF, 16'h0001, 16'h0000, 16'hFFFF, 1'b0);
        drain();
        tbl_mode = 1'b0;

        // Direction reversal mid-ramp.
        do_reset();
        target_amp = 16'hFFFF;
        run_stream(128, 16'h1000, 1'b0, 0, 0);
        check("rev_pre_amp", cur_amp, 16'h8000);
        check("rev_pre_ramping", ramping, 1'b1);
        target_amp = 16'h0000;
        run_stream(1, 16'h1000, 1'b0, 0, 0);
        check("rev_amp", cur_amp, 16'h7F00);
        check("rev_ramping", ramping, 1'b1);
        drain();
`endif

        // Reset with two samples in flight and the output stalled.
        target_amp       = 16'h0800;
        sample_in        = 16'h2000;
        sample_in_valid  = 1'b1;
        sample_out_ready = 1'b0;
        repeat (2) @(posedge Clk);
        #1;
        check("inflight_out_vld", sample_out_valid, 1'b1);
        check("inflight_in_ready", sample_in_ready, 1'b0);
        Reset = 1'b0;
        #1;
        check("rst_comb_ready", sample_in_ready, 1'b1);
        @(posedge Clk);
        #1;
        check("midrst_out_vld", sample_out_valid, 1'b0);
        check("midrst_amp", cur_amp, 16'h0000);
        check("midrst_in_ready", sample_in_ready, 1'b1);
        sample_in_valid  = 1'b0;
        sample_out_ready = 1'b1;
        Reset = 1'b1;
        tbl_mode = 1'b1;
        send_one("post_rst", 16'h0080, 16'h4000, 16'h0000, 16'h0080, 1'b0);
        drain();
        tbl_mode = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
